// File: rtl/reconf_dsp_seq_pkg.sv
// Shared definitions for the reconf_dsp_seq microcode sequencer:
// control-word bit offsets, word-width helper and FSM encodings.
package reconf_dsp_seq_pkg;

  localparam int PA_L    = 0;
  localparam int PD_L    = 1;
  localparam int PC_L    = 2;
  localparam int PI_R    = 3;
  localparam int PP_L    = 4;
  localparam int OMUX    = 5;
  localparam int LOOP    = 6;
  localparam int HALT    = 7;
  localparam int CMD_LSB = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int insn_width(input int cmd_w, input int pa_w,
                                    input int pd_w, input int pf_w);
    return 8 + cmd_w + pa_w + pd_w + pf_w;
  endfunction

endpackage

// File: rtl/reconf_dsp_seq_ram.sv
// Program store: synchronous write, asynchronous read, no reset so the
// program survives a sequencer reset.
module reconf_dsp_seq_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 26
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/reconf_dsp_seq.sv
// Microcode sequencer driving the exe_* bus of a reconf_dsp_elem stage:
// issues one control word per accepted cycle with loop, halt and stop.
module reconf_dsp_seq
  import reconf_dsp_seq_pkg::*;
#(
  parameter int PROG_BITS    = 6,
  parameter int FIFO_PA_BITS = 5,
  parameter int FIFO_PD_BITS = 5,
  parameter int FIFO_PF_BITS = 5,
  parameter int CMD_WIDTH    = 3,
  parameter int ITER_BITS    = 16,
  localparam int INSN_WIDTH  = insn_width(CMD_WIDTH, FIFO_PA_BITS,
                                          FIFO_PD_BITS, FIFO_PF_BITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [PROG_BITS-1:0]    cfg_addr,
  input  logic [INSN_WIDTH-1:0]   cfg_data,
  input  logic [PROG_BITS-1:0]    cfg_loop_start,
  input  logic                    ctl_start,
  input  logic                    ctl_stop,
  output logic [FIFO_PA_BITS-1:0] exe_faa,
  output logic [FIFO_PD_BITS-1:0] exe_fad,
  output logic [FIFO_PF_BITS-1:0] exe_fac,
  output logic                    exe_pa_l,
  output logic                    exe_pd_l,
  output logic                    exe_pc_l,
  output logic                    exe_pi_r,
  output logic                    exe_pp_l,
  output logic [CMD_WIDTH-1:0]    exe_cmd,
  output logic                    exe_cfg_omux,
  input  logic                    exe_ready,
  output logic                    st_busy,
  output logic [PROG_BITS-1:0]    st_pc,
  output logic [ITER_BITS-1:0]    st_iter,
  output logic                    st_cfg_err
);

  localparam int FAA_LSB = CMD_LSB + CMD_WIDTH;
  localparam int FAD_LSB = FAA_LSB + FIFO_PA_BITS;
  localparam int FAC_LSB = FAD_LSB + FIFO_PD_BITS;

  state_t                state_q, state_d;
  logic [INSN_WIDTH-1:0] ir_q, ir_d;
  logic [PROG_BITS-1:0]  pc_q, pc_d;
  logic [ITER_BITS-1:0]  iter_q, iter_d;
  logic                  stop_q, stop_d;
  logic                  err_q;

  logic                  wr_en;
  logic [PROG_BITS-1:0]  next_addr, rd_addr;
  logic [INSN_WIDTH-1:0] rd_word, start_word;
  logic [ITER_BITS-1:0]  iter_inc;
  logic                  ir_v;

  assign ir_v      = (state_q == RUN);
  assign wr_en     = cfg_we && (state_q == IDLE);
  assign next_addr = ir_q[LOOP] ? cfg_loop_start : pc_q + PROG_BITS'(1);
  assign rd_addr   = ir_v ? next_addr : '0;
  // Same-cycle write + start: word 0 must reflect the write landing first.
  assign start_word = (wr_en && cfg_addr == '0) ? cfg_data : rd_word;
  assign iter_inc   = (iter_q == '1) ? iter_q : iter_q + ITER_BITS'(1);

  reconf_dsp_seq_ram #(
    .ADDR_W (PROG_BITS),
    .DATA_W (INSN_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    iter_d  = iter_q;
    stop_d  = stop_q;
    case (state_q)
      IDLE: begin
        if (ctl_start) begin
          ir_d    = start_word;
          pc_d    = '0;
          iter_d  = '0;
          stop_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ctl_stop) stop_d = 1'b1;
        if (exe_ready) begin
          if (ir_q[HALT]) begin
            state_d = IDLE;
          end else if (ir_q[LOOP] && (stop_q || ctl_stop)) begin
            iter_d  = iter_inc;
            state_d = IDLE;
          end else begin
            if (ir_q[LOOP]) iter_d = iter_inc;
            pc_d = next_addr;
            ir_d = rd_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      iter_q  <= '0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      iter_q  <= iter_d;
      stop_q  <= stop_d;
      if (cfg_we && ir_v) err_q <= 1'b1;
    end
  end

  assign exe_pa_l     = ir_q[PA_L] & ir_v;
  assign exe_pd_l     = ir_q[PD_L] & ir_v;
  assign exe_pc_l     = ir_q[PC_L] & ir_v;
  assign exe_pi_r     = ir_q[PI_R] & ir_v;
  assign exe_pp_l     = ir_q[PP_L] & ir_v;
  assign exe_cfg_omux = ir_q[OMUX];
  assign exe_cmd      = ir_q[CMD_LSB +: CMD_WIDTH];
  assign exe_faa      = ir_q[FAA_LSB +: FIFO_PA_BITS];
  assign exe_fad      = ir_q[FAD_LSB +: FIFO_PD_BITS];
  assign exe_fac      = ir_q[FAC_LSB +: FIFO_PF_BITS];
  assign st_busy      = ir_v;
  assign st_pc        = pc_q;
  assign st_iter      = iter_q;
  assign st_cfg_err   = err_q;

endmodule

// File: tb/tb_reconf_dsp_seq.sv
// Directed scoreboard bench for reconf_dsp_seq: linear, backpressure, loop/stop,
// wrap-around (2-bit program), config error, write/start bypass and mid-run reset.
module tb_reconf_dsp_seq;
  import reconf_dsp_seq_pkg::*;

  localparam int IW = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cfg_we, ctl_start, ctl_stop, exe_ready;
  logic [5:0]    cfg_addr, cfg_loop_start;
  logic [IW-1:0] cfg_data;
  logic [4:0]    exe_faa, exe_fad, exe_fac;
  logic          exe_pa_l, exe_pd_l, exe_pc_l, exe_pi_r, exe_pp_l, exe_cfg_omux;
  logic [2:0]    exe_cmd;
  logic          st_busy, st_cfg_err;
  logic [5:0]    st_pc;
  logic [15:0]   st_iter;

  logic          w_rst, w_we, w_start, w_stop, w_ready;
  logic [1:0]    w_addr, w_loop_start;
  logic [IW-1:0] w_data;
  logic [4:0]    w_faa, w_fad, w_fac;
  logic          w_pa_l, w_pd_l, w_pc_l, w_pi_r, w_pp_l, w_omux;
  logic [2:0]    w_cmd;
  logic          w_busy, w_err;
  logic [1:0]    w_pc;
  logic [15:0]   w_iter;

  reconf_dsp_seq dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_loop_start(cfg_loop_start), .ctl_start(ctl_start), .ctl_stop(ctl_stop),
    .exe_faa(exe_faa), .exe_fad(exe_fad), .exe_fac(exe_fac),
    .exe_pa_l(exe_pa_l), .exe_pd_l(exe_pd_l), .exe_pc_l(exe_pc_l), .exe_pi_r(exe_pi_r),
    .exe_pp_l(exe_pp_l), .exe_cmd(exe_cmd), .exe_cfg_omux(exe_cfg_omux),
    .exe_ready(exe_ready), .st_busy(st_busy), .st_pc(st_pc), .st_iter(st_iter),
    .st_cfg_err(st_cfg_err)
  );

  reconf_dsp_seq #(.PROG_BITS(2)) u_wrap (
    .clk(clk), .rst(w_rst), .cfg_we(w_we), .cfg_addr(w_addr), .cfg_data(w_data),
    .cfg_loop_start(w_loop_start), .ctl_start(w_start), .ctl_stop(w_stop),
    .exe_faa(w_faa), .exe_fad(w_fad), .exe_fac(w_fac),
    .exe_pa_l(w_pa_l), .exe_pd_l(w_pd_l), .exe_pc_l(w_pc_l), .exe_pi_r(w_pi_r),
    .exe_pp_l(w_pp_l), .exe_cmd(w_cmd), .exe_cfg_omux(w_omux),
    .exe_ready(w_ready), .st_busy(w_busy), .st_pc(w_pc), .st_iter(w_iter),
    .st_cfg_err(w_err)
  );

  typedef struct {
    logic        busy;
    logic [5:0]  pc;
    logic        pp;
    logic [2:0]  cmd;
    logic [15:0] iter;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic pp, input logic loop,
                                       input logic halt, input logic [2:0] cmd);
    logic [IW-1:0] w;
    w = '0;
    w[PP_L] = pp;
    w[LOOP] = loop;
    w[HALT] = halt;
    w[CMD_LSB +: 3] = cmd;
    w[11 +: 5] = {2'b00, cmd} + 5'd3;
    return w;
  endfunction

  task automatic push(input logic busy, input logic [5:0] pc, input logic pp,
                      input logic [2:0] cmd, input logic [15:0] iter);
    exp_t e;
    e.busy = busy; e.pc = pc; e.pp = pp; e.cmd = cmd; e.iter = iter;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, got pc %0d busy %0d", tag, st_pc, st_busy);
    end else begin
      e = sb.pop_front();
      cmp({tag, "_busy"}, 32'(st_busy), 32'(e.busy));
      cmp({tag, "_pp"}, 32'(exe_pp_l), 32'(e.pp));
      cmp({tag, "_iter"}, 32'(st_iter), 32'(e.iter));
      if (e.busy) begin
        cmp({tag, "_pc"}, 32'(st_pc), 32'(e.pc));
        cmp({tag, "_cmd"}, 32'(exe_cmd), 32'(e.cmd));
        cmp({tag, "_faa"}, 32'(exe_faa), 32'({2'b00, e.cmd} + 5'd3));
      end
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [IW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    ctl_start = 1'b1;
    step();
    ctl_start = 1'b0;
  endtask

  task automatic load_linear();
    for (int i = 0; i < 5; i++) wr(6'(i), mk(1'b1, 1'b0, i == 3, 3'(i)));
  endtask

  task automatic push_linear();
    for (int i = 0; i < 4; i++) push(1'b1, 6'(i), 1'b1, 3'(i), 16'd0);
    push(1'b0, 6'd0, 1'b0, 3'd0, 16'd0);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_strobes"}, 32'({exe_pa_l, exe_pd_l, exe_pc_l, exe_pi_r, exe_pp_l}), 32'd0);
    cmp({tag, "_fields"}, 32'({exe_faa, exe_fad, exe_fac, exe_cmd, exe_cfg_omux}), 32'd0);
    cmp({tag, "_status"}, 32'({st_busy, st_pc, st_iter, st_cfg_err}), 32'd0);
  endtask

  initial begin
    bit rp[7];
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_loop_start = '0;
    ctl_start = 1'b0; ctl_stop = 1'b0; exe_ready = 1'b1;
    w_rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0; w_loop_start = '0;
    w_start = 1'b0; w_stop = 1'b0; w_ready = 1'b1;
    step(); step();
    rst = 1'b0; w_rst = 1'b0;
    check_zero("reset");

    // linear program, HALT on word 3
    load_linear();
    push_linear();
    push(1'b0, 6'd0, 1'b0, 3'd0, 16'd0);
    go(); check("lin0");
    for (int i = 0; i < 5; i++) begin step(); check("lin"); end

    // backpressure while word 1 is presented
    rp = '{1, 0, 0, 0, 1, 1, 1};
    push(1'b1, 6'd0, 1'b1, 3'd0, 16'd0);
    for (int i = 0; i < 4; i++) push(1'b1, 6'd1, 1'b1, 3'd1, 16'd0);
    push(1'b1, 6'd2, 1'b1, 3'd2, 16'd0);
    push(1'b1, 6'd3, 1'b1, 3'd3, 16'd0);
    push(1'b0, 6'd0, 1'b0, 3'd0, 16'd0);
    go(); check("bp0");
    for (int i = 0; i < 7; i++) begin exe_ready = rp[i]; step(); check("bp"); end
    exe_ready = 1'b1;

    // loop 1..2, stop raised during the third iteration
    cfg_loop_start = 6'd1;
    wr(6'd2, mk(1'b1, 1'b1, 1'b0, 3'd2));
    push(1'b1, 6'd0, 1'b1, 3'd0, 16'd0);
    push(1'b1, 6'd1, 1'b1, 3'd1, 16'd0);
    push(1'b1, 6'd2, 1'b1, 3'd2, 16'd0);
    push(1'b1, 6'd1, 1'b1, 3'd1, 16'd1);
    push(1'b1, 6'd2, 1'b1, 3'd2, 16'd1);
    push(1'b1, 6'd1, 1'b1, 3'd1, 16'd2);
    push(1'b1, 6'd2, 1'b1, 3'd2, 16'd2);
    push(1'b0, 6'd0, 1'b0, 3'd0, 16'd3);
    push(1'b0, 6'd0, 1'b0, 3'd0, 16'd3);
    go(); check("loop0");
    for (int i = 1; i < 9; i++) begin
      ctl_stop = (i == 6);
      step();
      ctl_stop = 1'b0;
      check("loop");
    end
    cmp("loop_iter_final", 32'(st_iter), 32'd3);

    // stop in the same cycle as the retiring LOOP word
    push(1'b1, 6'd0, 1'b1, 3'd0, 16'd0);
    push(1'b1, 6'd1, 1'b1, 3'd1, 16'd0);
    push(1'b1, 6'd2, 1'b1, 3'd2, 16'd0);
    push(1'b0, 6'd0, 1'b0, 3'd0, 16'd1);
    go(); check("stopnow0");
    for (int i = 1; i < 4; i++) begin
      ctl_stop = (i == 3);
      step();
      ctl_stop = 1'b0;
      check("stopnow");
    end

    // write while busy is dropped and flagged
    load_linear();
    cmp("err_before", 32'(st_cfg_err), 32'd0);
    push_linear();
    go(); check("err0");
    for (int i = 1; i < 5; i++) begin
      cfg_we = (i == 2); cfg_addr = 6'd0; cfg_data = mk(1'b0, 1'b0, 1'b1, 3'd7);
      step();
      cfg_we = 1'b0;
      check("err");
    end
    cmp("err_sticky", 32'(st_cfg_err), 32'd1);
    push_linear();
    go(); check("err_replay0");
    for (int i = 0; i < 4; i++) begin step(); check("err_replay"); end

    // write and start together: word 0 comes through the bypass
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = mk(1'b1, 1'b0, 1'b1, 3'd6);
    ctl_start = 1'b1;
    push(1'b1, 6'd0, 1'b1, 3'd6, 16'd0);
    push(1'b0, 6'd0, 1'b0, 3'd0, 16'd0);
    step();
    cfg_we = 1'b0; ctl_start = 1'b0;
    check("bypass"); step(); check("bypass_end");
    cmp("bypass_err_kept", 32'(st_cfg_err), 32'd1);
    wr(6'd0, mk(1'b1, 1'b0, 1'b0, 3'd0));

    // reset mid-run, then replay from word 0
    push(1'b1, 6'd0, 1'b1, 3'd0, 16'd0);
    push(1'b1, 6'd1, 1'b1, 3'd1, 16'd0);
    go(); check("rst0"); step(); check("rst1");
    rst = 1'b1; step(); rst = 1'b0;
    check_zero("rst_mid");
    step();
    cmp("rst_idle_busy", 32'(st_busy), 32'd0);
    push_linear();
    go(); check("rst_replay0");
    for (int i = 0; i < 4; i++) begin step(); check("rst_replay"); end

    // wrap-around on the 2-bit program
    for (int i = 0; i < 4; i++) begin
      w_we = 1'b1; w_addr = 2'(i); w_data = mk(1'b1, 1'b0, 1'b0, 3'(i));
      step();
    end
    w_we = 1'b0;
    w_start = 1'b1; step(); w_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cmp("wrap_pc", 32'(w_pc), 32'(i % 4));
      cmp("wrap_busy", 32'(w_busy), 32'd1);
      cmp("wrap_cmd", 32'(w_cmd), 32'(i % 4));
      cmp("wrap_iter", 32'(w_iter), 32'd0);
      step();
    end
    w_rst = 1'b1; step(); w_rst = 1'b0;
    cmp("wrap_rst_busy", 32'(w_busy), 32'd0);

    cmp("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reconf_dsp_seq.md
# reconf_dsp_seq

Microcode sequencer that drives the `exe_*` control bus of one `reconf_dsp_elem` stage (or a cascade chain sharing one bus). It holds a small program of wide control words and issues one word per cycle while the DSP stage accepts commands. It advances its program counter only when `exe_ready` is high, and supports looping, halting and graceful stop. Software loads the program through a simple write port while the sequencer is idle.

## Interface
**Parameters**
- PROG_BITS, 6: program address width; depth is 2^PROG_BITS words.
- FIFO_PA_BITS, 5: width of `exe_faa`.
- FIFO_PD_BITS, 5: width of `exe_fad`.
- FIFO_PF_BITS, 5: width of `exe_fac`.
- CMD_WIDTH, 3: width of `exe_cmd`.
- ITER_BITS, 16: width of the iteration counter.
- INSN_WIDTH, derived: 8 + CMD_WIDTH + FIFO_PA_BITS + FIFO_PD_BITS + FIFO_PF_BITS.

**Ports**
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- cfg_we  in  1  program word write strobe.
- cfg_addr  in  PROG_BITS  program write address.
- cfg_data  in  INSN_WIDTH  program word.
- cfg_loop_start  in  PROG_BITS  loop target address; sampled whenever a loop word retires.
- ctl_start  in  1  start pulse.
- ctl_stop  in  1  request to stop at the end of the current iteration.
- exe_faa / exe_fad / exe_fac  out  FIFO_*_BITS  stack register addresses.
- exe_pa_l, exe_pd_l, exe_pc_l, exe_pi_r, exe_pp_l  out  1  load, consume and push strobes.
- exe_cmd  out  CMD_WIDTH  DSP opcode.
- exe_cfg_omux  out  1  bypass mux select.
- exe_ready  in  1  command accepted by the DSP stage.
- st_busy  out  1  sequencer is issuing words.
- st_pc  out  PROG_BITS  address of the word currently presented.
- st_iter  out  ITER_BITS  completed loop iterations.
- st_cfg_err  out  1  sticky flag: `cfg_we` was asserted while busy.

## Operation
**Word layout**, LSB first:
- bits 0..4: pa_l, pd_l, pc_l, pi_r, pp_l.
- bit 5: omux.
- bit 6: LOOP.
- bit 7: HALT.
- then cmd, faa, fad, fac.

**Registers**
- Program RAM: asynchronous read, not reset.
- Instruction register `ir`, valid bit `ir_v`, `pc`, `stop_pend`.

**Outputs**
- All address, cmd and omux fields come directly from `ir`.
- The five strobes are `ir` bits ANDed with `ir_v`.
- When idle, the strobes are 0 and the fields hold their last value.

**States**
- IDLE (`ir_v` = 0):
  - `ctl_start`: `ir` <= prog[0], `pc` <= 0, `st_iter` <= 0, `stop_pend` <= 0, go to RUN.
  - `ctl_stop` in IDLE is ignored.
- RUN (`ir_v` = 1). A word retires on any cycle with `exe_ready` = 1. On retire, evaluate in this priority order:
  1. HALT set: go to IDLE.
  2. LOOP set and `stop_pend`: `st_iter`++, go to IDLE.
  3. LOOP set: `st_iter`++, next address is `cfg_loop_start`.
  4. Otherwise: next address is `pc`+1, wrapping from 2^PROG_BITS−1 to 0.
  
  The next address is loaded into `pc`, and `ir` <= prog[next].
- While RUN and `exe_ready` = 0: hold `ir` and `pc`.
- `ctl_stop` in RUN sets `stop_pend`. `ctl_start` in RUN is ignored.
- `st_iter` saturates at all-ones.

**Program writes**
- `cfg_we` is honoured only in IDLE.
- `cfg_we` while busy: the write is dropped and `st_cfg_err` <= 1. `st_cfg_err` is cleared only by `rst`.
- `cfg_we` and `ctl_start` in the same cycle: the write lands first, and prog[0] is read through the bypass (the new data when `cfg_addr` = 0).

## Timing
- Reset: every output is 0, the state is IDLE and `stop_pend` = 0. Program contents are kept.
- `ctl_start` at cycle N: word 0 is presented from cycle N+1 and `st_busy` = 1 from N+1.
- Throughput is one word per cycle when `exe_ready` stays 1. There are no bubbles on a LOOP branch.
- A retiring HALT or final LOOP word at cycle M: strobes and `st_busy` are 0 at M+1.
- `ctl_stop` in the same cycle as a retiring LOOP word takes effect on that word.
- `rst` mid-RUN: strobes are 0 on the next cycle and no partial word is reissued.
- `exe_ready` is combinational from the DSP stage. No output depends combinationally on `exe_ready`, so there is no loop.

## Structure
- Package `reconf_dsp_seq_pkg` holds:
  - bit offsets for PA_L, PD_L, PC_L, PI_R, PP_L, OMUX, LOOP, HALT, CMD_LSB;
  - the INSN_WIDTH function;
  - state encodings IDLE and RUN.
- Sub-module `reconf_dsp_seq_ram`: 2^PROG_BITS × INSN_WIDTH distributed RAM with a synchronous write port and an asynchronous read port.
- The FSM, `pc`, `ir` and counters live in the top module.

## Test plan
- **Linear program.** Load words 0..3 with `pp_l` = 1, word 3 with HALT, hold `exe_ready` = 1, pulse start. Required: `exe_pp_l` high for exactly 4 cycles, `st_pc` = 0, 1, 2, 3, then `st_busy` = 0.
- **Backpressure.** Same program, `exe_ready` = 0 for 3 cycles while presenting word 1. Required: word 1 stays on the bus 4 cycles and the total run is 7 cycles.
- **Loop and stop.** Set `cfg_loop_start` = 1 with LOOP on word 2. Required: `st_pc` sequence 0, 1, 2, 1, 2, … Pulse stop during the third iteration. Required: IDLE after that iteration's word 2 retires, `st_iter` = 3.
- **Wrap-around.** PROG_BITS = 2, no LOOP or HALT bits, stop never asserted. Required: `st_pc` cycles 0, 1, 2, 3, 0 and `st_iter` stays 0.
- **Configuration error.** `cfg_we` to address 0 while busy. Required: `st_cfg_err` = 1, and after the next start word 0 still has its old contents.
- **Reset mid-run.** `rst` while in RUN. Required: all outputs 0 next cycle, and a following start replays the program from word 0 unchanged.
